// File: rtl/bit_serial_adder.sv
// bit_serial_adder
//   Adds two WIDTH-bit unsigned operands one bit per clock through a single
//   full-adder slice and a carry flop. A parallel operand pair is captured on
//   an accepted start; the parallel sum and carry-out are returned with a
//   one-cycle done strobe. A start in the done cycle begins a new operation
//   immediately (one result per WIDTH+1 cycles).
//
//   Optional feature (macro BIT_SERIAL_ADDER_OVF_EN): adds the registered
//   signed-overflow output ovf.
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request an add (ignored while busy)
//   a, b   in   WIDTH-bit operands, captured on an accepted start
//   cin    in   carry-in, captured on an accepted start
//   busy   out  high while bits are being shifted through the slice
//   done   out  one-cycle pulse, result valid from this cycle
//   sum    out  WIDTH-bit registered result, held until the next done
//   cout   out  registered carry-out, held until the next done
//   ovf    out  (BIT_SERIAL_ADDER_OVF_EN only) two's-complement overflow
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef BIT_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] ra_reg, rb_reg;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [CW-1:0]    cnt_reg;
  logic             c_reg, c_next;
  logic             s_bit;
  logic             load;
  logic             last;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  // Single full-adder slice on the LSBs of the operand shift registers.
  assign s_bit  = ra_reg[0] ^ rb_reg[0] ^ c_reg;
  assign c_next = (ra_reg[0] & rb_reg[0]) | (rb_reg[0] & c_reg) | (ra_reg[0] & c_reg);

  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign acc_next = WIDTH'({s_bit, acc_reg} >> 1);

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_reg == LAST_BIT) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_reg   <= '0;
      rb_reg   <= '0;
      acc_reg  <= '0;
      cnt_reg  <= '0;
      c_reg    <= 1'b0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else begin
      if (load) begin
        ra_reg  <= a;
        rb_reg  <= b;
        acc_reg <= '0;
        cnt_reg <= '0;
        c_reg   <= cin;
      end else if (state_reg == SHIFT) begin
        ra_reg  <= ra_reg >> 1;
        rb_reg  <= rb_reg >> 1;
        acc_reg <= acc_next;
        cnt_reg <= cnt_reg + CW'(1);
        c_reg   <= c_next;
      end
      if (last) begin
        sum_reg  <= acc_next;
        cout_reg <= c_next;
      end
    end
  end

`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic ovf_reg;

  // On the last slice c_reg is the carry into the MSB and c_next the carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (last) begin
      ovf_reg <= c_reg ^ c_next;
    end
  end

  assign ovf = ovf_reg;
`endif

  // Decoded straight from the state register, so no input reaches these.
  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

  localparam int WIDTH = 8;
  localparam int LIMIT = 40;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int total;
  int bad;

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef BIT_SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation from 1 ns after an edge and returns in the done
  // cycle (1 ns after the edge that raised done), reporting the number of
  // edges from the start edge to done. timed_out is set if done never came.
  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic icin, output int lat, output bit timed_out);
    a     = ia;
    b     = ib;
    cin   = icin;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    timed_out = (done !== 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, cout, sum} !== {3'b000, 8'h00}) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b cout=%b sum=%h, want 0 0 0 00", busy, done, cout, sum);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
    end
    $display("reset: busy=%b done=%b sum=%h cout=%b", busy, done, sum, cout);
  endtask

  task automatic test_basic();
    int lat;
    a     = 8'h5A;
    b     = 8'h3C;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    for (int k = 1; k <= WIDTH; k++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL basic_busy cycle %0d: busy=%b done=%b, want 1 0", k, busy, done);
      end
      @(posedge clk); #1;
      lat = k;
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== 8'h96 || cout !== 1'b0) begin
      bad++;
      $display("FAIL basic_result after %0d edges: done=%b busy=%b sum=%h cout=%b, want 1 0 96 0",
               lat, done, busy, sum, cout);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || sum !== 8'h96) begin
      bad++;
      $display("FAIL basic_hold: done=%b sum=%h, want 0 96", done, sum);
    end
    $display("basic: 5a+3c+0 -> sum=%h cout=%b", sum, cout);
  endtask

  task automatic test_carry();
    int lat;
    bit to;
    run_op(8'hFF, 8'h01, 1'b0, lat, to);
    total++;
    if (to || lat != WIDTH || sum !== 8'h00 || cout !== 1'b1) begin
      bad++;
      $display("FAIL carry_ff_01: timeout=%0d lat=%0d sum=%h cout=%b, want 0 8 00 1", to, lat, sum, cout);
    end
    $display("carry: ff+01+0 -> sum=%h cout=%b", sum, cout);
    run_op(8'hFF, 8'h00, 1'b1, lat, to);
    total++;
    if (to || lat != WIDTH || sum !== 8'h00 || cout !== 1'b1) begin
      bad++;
      $display("FAIL carry_cin: timeout=%0d lat=%0d sum=%h cout=%b, want 0 8 00 1", to, lat, sum, cout);
    end
    $display("carry: ff+00+1 -> sum=%h cout=%b", sum, cout);
  endtask

  task automatic test_back_to_back();
    int lat;
    int dones;
    @(posedge clk); #1;
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    // start stays high and operands change while the first add is shifting
    a     = 8'hFF;
    b     = 8'hFF;
    dones = 0;
    lat   = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 1 || lat != WIDTH || sum !== 8'h46 || cout !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first: dones=%0d lat=%0d sum=%h cout=%b, want 1 8 46 0", dones, lat, sum, cout);
    end
    $display("b2b: 12+34+0 -> sum=%h cout=%b", sum, cout);
    // start is still high at the edge ending the done cycle: fresh load of ff+ff
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_restart: busy=%b done=%b, want 1 0", busy, done);
    end
    lat = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != WIDTH || sum !== 8'hFE || cout !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second: lat=%0d sum=%h cout=%b, want 8 fe 1", lat, sum, cout);
    end
    $display("b2b: ff+ff+0 -> sum=%h cout=%b", sum, cout);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    int dones;
    bit to;
    a     = 8'hAA;
    b     = 8'h55;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, cout, sum} !== {3'b000, 8'h00}) begin
      bad++;
      $display("FAIL midreset_async: busy=%b done=%b cout=%b sum=%h, want 0 0 0 00", busy, done, cout, sum);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 0 || busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      bad++;
      $display("FAIL midreset_discard: dones=%0d busy=%b sum=%h cout=%b, want 0 0 00 0", dones, busy, sum, cout);
    end
    $display("midreset: busy=%b sum=%h cout=%b", busy, sum, cout);
    run_op(8'hAA, 8'h55, 1'b1, lat, to);
    total++;
    if (to || lat != WIDTH || sum !== 8'h00 || cout !== 1'b1) begin
      bad++;
      $display("FAIL midreset_rerun: timeout=%0d lat=%0d sum=%h cout=%b, want 0 8 00 1", to, lat, sum, cout);
    end
    $display("midreset: aa+55+1 -> sum=%h cout=%b", sum, cout);
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat;
    bit to;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic [WIDTH:0]   want;
    for (int n = 0; n < 1000; n++) begin
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      rc   = 1'($urandom);
      want = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      run_op(ra, rb, rc, lat, to);
      total++;
      if (to || lat != WIDTH || {cout, sum} !== want) begin
        bad++;
        $display("FAIL rand_%0d: %h+%h+%b timeout=%0d lat=%0d got %b_%h, want lat 8 %b_%h",
                 n, ra, rb, rc, to, lat, cout, sum, want[WIDTH], want[WIDTH-1:0]);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL rand_done_width_%0d: done=%b one cycle after done, want 0", n, done);
      end
      $display("rand %0d: %h+%h+%b -> cout=%b sum=%h", n, ra, rb, rc, cout, sum);
    end
  endtask

`ifdef BIT_SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    int lat;
    bit to;
    run_op(8'h7F, 8'h01, 1'b0, lat, to);
    total++;
    if (to || sum !== 8'h80 || ovf !== 1'b1 || cout !== 1'b0) begin
      bad++;
      $display("FAIL ovf_7f_01: sum=%h ovf=%b cout=%b, want 80 1 0", sum, ovf, cout);
    end
    $display("ovf: 7f+01 -> sum=%h ovf=%b cout=%b", sum, ovf, cout);
    run_op(8'h80, 8'h80, 1'b0, lat, to);
    total++;
    if (to || sum !== 8'h00 || ovf !== 1'b1 || cout !== 1'b1) begin
      bad++;
      $display("FAIL ovf_80_80: sum=%h ovf=%b cout=%b, want 00 1 1", sum, ovf, cout);
    end
    $display("ovf: 80+80 -> sum=%h ovf=%b cout=%b", sum, ovf, cout);
    run_op(8'h10, 8'h20, 1'b0, lat, to);
    total++;
    if (to || sum !== 8'h30 || ovf !== 1'b0 || cout !== 1'b0) begin
      bad++;
      $display("FAIL ovf_10_20: sum=%h ovf=%b cout=%b, want 30 0 0", sum, ovf, cout);
    end
    $display("ovf: 10+20 -> sum=%h ovf=%b cout=%b", sum, ovf, cout);
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_reset_mid();
`ifdef BIT_SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
